// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell and a carry flop reused over WIDTH
// cycles, LSB-first, with the parallel sum/carry presented on completion.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             s_bit,
  output logic             s_valid,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             done
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [WIDTH-1:0] r_res;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_s;
  logic             r_cout;

  logic             w_sum;
  logic             w_carry_nxt;
  logic [WIDTH-1:0] w_res_nxt;
  logic             w_last;

  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  assign w_sum       = r_a[0] ^ r_b[0] ^ r_carry;
  assign w_carry_nxt = maj3(r_a[0], r_b[0], r_carry);
  // New sum bit enters at the MSB so the LSB lands in bit 0 after WIDTH shifts.
  assign w_res_nxt   = (r_res >> 1) | (WIDTH'(w_sum) << (WIDTH - 1));
  assign w_last      = (r_cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_res   <= '0;
      r_cnt   <= '0;
      r_s     <= '0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a     <= A;
            r_b     <= B;
            r_carry <= Cin;
            r_cnt   <= '0;
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_carry <= w_carry_nxt;
          r_res   <= w_res_nxt;
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_s     <= w_res_nxt;
            r_cout  <= w_carry_nxt;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy    = (r_state == ST_SHIFT);
  assign s_valid = (r_state == ST_SHIFT);
  assign s_bit   = w_sum;
  assign done    = (r_state == ST_DONE);
  assign S       = r_s;
  assign Cout    = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: an 8-bit instance for the main scenarios
// and a 1-bit instance for the single-cycle sweep.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] A;
  logic [7:0] B;
  logic       Cin;
  logic       busy;
  logic       s_bit;
  logic       s_valid;
  logic [7:0] S;
  logic       Cout;
  logic       done;

  logic start1;
  logic A1;
  logic B1;
  logic Cin1;
  logic busy1;
  logic s_bit1;
  logic s_valid1;
  logic S1;
  logic Cout1;
  logic done1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .Cin(Cin),
    .busy(busy), .s_bit(s_bit), .s_valid(s_valid), .S(S), .Cout(Cout), .done(done)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .A(A1), .B(B1), .Cin(Cin1),
    .busy(busy1), .s_bit(s_bit1), .s_valid(s_valid1), .S(S1), .Cout(Cout1), .done(done1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one operation on the 8-bit instance; lat is the number of edges
  // from the accepting edge to the first cycle with done=1 (-1 on timeout).
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                       output logic [7:0] s, output logic c, output int lat);
    start = 1'b1; A = a; B = b; Cin = cin;
    tick();
    start = 1'b0; A = ~a; B = ~b; Cin = ~cin;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (done === 1'b1) begin
        lat = i;
        break;
      end
    end
    s = S;
    c = Cout;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; A = 8'hAA; B = 8'h55; Cin = 1'b1;
    start1 = 1'b0; A1 = 1'b0; B1 = 1'b0; Cin1 = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    vectors++;
    if ({S, Cout, done, busy, s_valid} !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_state: S=%h Cout=%b done=%b busy=%b s_valid=%b, want all 0",
               S, Cout, done, busy, s_valid);
    end
    vectors++;
    if ({S1, Cout1, done1, busy1} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_state_w1: S=%b Cout=%b done=%b busy=%b, want 0",
               S1, Cout1, done1, busy1);
    end
  endtask

  task automatic test_serial_bits();
    logic [7:0] exp_bits;
    exp_bits = 8'b0111_1111;
    start = 1'b1; A = 8'h35; B = 8'h4A; Cin = 1'b0;
    tick();
    start = 1'b0; A = 8'h00; B = 8'h00;
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (s_valid !== 1'b1 || busy !== 1'b1 || s_bit !== exp_bits[i] || done !== 1'b0) begin
        miscompares++;
        $display("FAIL serial_bit%0d: s_bit=%b s_valid=%b busy=%b done=%b, want s_bit=%b 1 1 0",
                 i, s_bit, s_valid, busy, done, exp_bits[i]);
      end
      tick();
    end
    vectors++;
    if (done !== 1'b1 || S !== 8'h7F || Cout !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL serial_result: done=%b S=%h Cout=%b busy=%b, want 1 7f 0 0",
               done, S, Cout, busy);
    end
    tick();
    vectors++;
    if (done !== 1'b0 || s_valid !== 1'b0 || S !== 8'h7F) begin
      miscompares++;
      $display("FAIL serial_after: done=%b s_valid=%b S=%h, want 0 0 7f", done, s_valid, S);
    end
  endtask

  task automatic test_carry();
    logic [7:0] s;
    logic       c;
    int         lat;
    do_op(8'hFF, 8'h01, 1'b0, s, c, lat);
    vectors++;
    if ({c, s} !== 9'h100 || lat != 8) begin
      miscompares++;
      $display("FAIL carry_ripple: {Cout,S}=%h lat=%0d, want 100 lat=8", {c, s}, lat);
    end
    do_op(8'hFF, 8'hFF, 1'b1, s, c, lat);
    vectors++;
    if ({c, s} !== 9'h1FF || lat != 8) begin
      miscompares++;
      $display("FAIL carry_max: {Cout,S}=%h lat=%0d, want 1ff lat=8", {c, s}, lat);
    end
    do_op(8'h12, 8'h34, 1'b1, s, c, lat);
    vectors++;
    if ({c, s} !== 9'h047 || lat != 8) begin
      miscompares++;
      $display("FAIL carry_cin: {Cout,S}=%h lat=%0d, want 047 lat=8", {c, s}, lat);
    end
  endtask

  task automatic test_start_ignored();
    int pulses;
    start = 1'b1; A = 8'h12; B = 8'h34; Cin = 1'b0;
    tick();
    start = 1'b0;
    tick();
    tick();
    start = 1'b1; A = 8'h00; B = 8'h00;
    tick();
    start = 1'b0;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL ignore_busy: busy=%b, want 1", busy);
    end
    pulses = 0;
    for (int i = 0; i < 14; i++) begin
      if (done === 1'b1) pulses++;
      tick();
    end
    vectors++;
    if (pulses != 1 || S !== 8'h46 || Cout !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL ignore_start: pulses=%0d S=%h Cout=%b busy=%b, want 1 46 0 0",
               pulses, S, Cout, busy);
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    start = 1'b1; A = 8'hF0; B = 8'h0F; Cin = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if (busy !== 1'b0 || S !== 8'h00 || Cout !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: busy=%b S=%h Cout=%b done=%b, want 0 00 0 0",
               busy, S, Cout, done);
    end
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) pulses++;
    end
    vectors++;
    if (pulses != 0) begin
      miscompares++;
      $display("FAIL reset_mid_quiet: done/busy cycles=%0d, want 0", pulses);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] ta [3];
    logic [7:0] tb [3];
    logic       tc [3];
    logic [8:0] te [3];
    int n;
    int last_done;
    int since_done;
    ta[0] = 8'h10; tb[0] = 8'h20; tc[0] = 1'b0; te[0] = 9'h030;
    ta[1] = 8'h80; tb[1] = 8'h80; tc[1] = 1'b1; te[1] = 9'h101;
    ta[2] = 8'hC3; tb[2] = 8'h3C; tc[2] = 1'b1; te[2] = 9'h100;
    start = 1'b1; A = ta[0]; B = tb[0]; Cin = tc[0];
    tick();
    A = 8'h5A; B = 8'hA5; Cin = 1'b0;
    n = 0;
    last_done = 0;
    since_done = -1;
    for (int t = 1; t <= 40 && n < 3; t++) begin
      tick();
      if (since_done >= 0) since_done++;
      if (since_done == 2) begin
        A = 8'h5A; B = 8'hA5; Cin = 1'b0;
      end
      if (done === 1'b1) begin
        vectors++;
        if ({Cout, S} !== te[n] || (n > 0 && t - last_done != 10) || (n == 0 && t != 8)) begin
          miscompares++;
          $display("FAIL back_to_back%0d: {Cout,S}=%h at t=%0d (prev %0d), want %h",
                   n, {Cout, S}, t, last_done, te[n]);
        end
        last_done = t;
        since_done = 0;
        n++;
        if (n < 3) begin
          A = ta[n]; B = tb[n]; Cin = tc[n];
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    vectors++;
    if (n != 3) begin
      miscompares++;
      $display("FAIL back_to_back_count: done pulses=%0d, want 3", n);
    end
    tick();
    tick();
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL back_to_back_drain: busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_width1();
    logic [1:0] exp;
    for (int i = 0; i < 8; i++) begin
      start1 = 1'b1; A1 = i[2]; B1 = i[1]; Cin1 = i[0];
      tick();
      start1 = 1'b0; A1 = ~A1; B1 = ~B1; Cin1 = ~Cin1;
      exp = 2'(i[2]) + 2'(i[1]) + 2'(i[0]);
      vectors++;
      if (busy1 !== 1'b1 || s_bit1 !== exp[0]) begin
        miscompares++;
        $display("FAIL w1_shift%0d: busy=%b s_bit=%b, want 1 %b", i, busy1, s_bit1, exp[0]);
      end
      tick();
      vectors++;
      if (done1 !== 1'b1 || {Cout1, S1} !== exp) begin
        miscompares++;
        $display("FAIL w1_sum%0d: done=%b {Cout,S}=%b, want 1 %b", i, done1, {Cout1, S1}, exp);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_serial_bits();
    test_carry();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    test_width1();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
